timer_bus_arbiter: RTL and testbench



---
 rtl/timer_bus_arbiter_pkg.sv | 28 ++
 rtl/timer_bus_arbiter_if.sv | 46 ++++
 rtl/timer_bus_arbiter_rr_picker.sv | 41 ++++
 rtl/timer_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_timer_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_bus_arbiter_pkg.sv
// Shared types, default widths and the reference round-robin helper for
// the timer bus arbiter.
package timer_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   localparam int ARB_ADDR_W = 8;
   localparam int ARB_DATA_W = 32;
   localparam int ARB_MAX_M  = 8;

   // Index of the first requester after 'last', wrapping modulo n.
   // Returns -1 when nobody requests. n must be 2..ARB_MAX_M.
   function automatic int rr_next(input logic [ARB_MAX_M-1:0] req,
                                  input int last, input int n);
      int cand;
      rr_next = -1;
      // Walk from the farthest candidate down so the nearest one wins.
      for (int off = n; off >= 1; off--) begin
         cand = (last + off) % n;
         if (req[cand[2:0]]) rr_next = cand;
      end
   endfunction

endpackage

// File: rtl/timer_bus_arbiter_if.sv
// Bundle of requester-side and timer-slave-side signals around the arbiter.
// The 'slave' modport is the arbiter's view (it serves the requesters and
// drives the timer bus); 'master' is the view of the surrounding system.
// Optional macro TIMER_ARB_TIMEOUT_EN adds the per-master m_err pulse.
interface timer_bus_arbiter_if
   import timer_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_W      = ARB_ADDR_W,
   parameter int DATA_W      = ARB_DATA_W
);
   logic [NUM_MASTERS-1:0]        m_req;
   logic [NUM_MASTERS-1:0]        m_we;
   logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
   logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
   logic [NUM_MASTERS-1:0]        m_gnt;
   logic [NUM_MASTERS-1:0]        m_done;
   logic [DATA_W-1:0]             m_rdata;
`ifdef TIMER_ARB_TIMEOUT_EN
   logic [NUM_MASTERS-1:0]        m_err;
`endif
   logic                          s_sel;
   logic                          s_we;
   logic [ADDR_W-1:0]             s_addr;
   logic [DATA_W-1:0]             s_wdata;
   logic [DATA_W-1:0]             s_rdata;
   logic                          s_ready;
   logic                          busy;

   modport slave (
      input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
      output m_gnt, m_done, m_rdata, s_sel, s_we, s_addr, s_wdata, busy
`ifdef TIMER_ARB_TIMEOUT_EN
      , output m_err
`endif
   );

   modport master (
      output m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
      input  m_gnt, m_done, m_rdata, s_sel, s_we, s_addr, s_wdata, busy
`ifdef TIMER_ARB_TIMEOUT_EN
      , input m_err
`endif
   );

endinterface

// File: rtl/timer_bus_arbiter_rr_picker.sv
// Combinational round-robin selector: the first requester after 'last'
// (wrapping) wins. Produces a valid flag, the winner index and a one-hot grant.
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          valid,
   output logic [IW-1:0] idx,
   output logic [N-1:0]  gnt
);
   logic [2*N-1:0] dbl;
   logic [2*N-1:0] rot_full;
   logic [N-1:0]   rot;
   logic [IW:0]    shift;
   logic [IW:0]    sum;
   logic [IW-1:0]  pos;

   // Rotate requests so bit 0 is the highest-priority master, pick the
   // lowest set bit, then rotate the position back to a master index.
   always_comb begin
      // NOTE: combinational logic uses blocking '=' so each statement sees the
      // value computed just above it; every output is assigned up front, so
      // no path through the block can leave a latch behind.
      dbl      = {req, req};
      shift    = {1'b0, last} + (IW+1)'(1);
      rot_full = dbl >> shift;
      rot      = rot_full[N-1:0];
      pos      = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (rot[i]) pos = IW'(i);
      end
      sum = shift + {1'b0, pos};
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      valid = |req;
      idx   = sum[IW-1:0];
      gnt   = valid ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter sharing the timer register bus among NUM_MASTERS
// requesters. One transaction at a time: IDLE (arbitrate and latch),
// ACCESS (drive slave until ready), RESP (one-cycle done pulse).
// Optional macro TIMER_ARB_TIMEOUT_EN bounds ACCESS to TIMEOUT_CYC cycles
// and reports an expired access through m_err.
module timer_bus_arbiter
   import timer_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_W      = ARB_ADDR_W,
   parameter int DATA_W      = ARB_DATA_W
`ifdef TIMER_ARB_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 16
`endif
) (
   input  logic clk,
   input  logic rst,
   timer_bus_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_MASTERS);

   arb_state_e state, state_next;

   logic [IW-1:0]          last_q;
   logic [IW-1:0]          idx_q;
   logic [NUM_MASTERS-1:0] gnt_q;
   logic                   we_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [DATA_W-1:0]      wdata_q;
   logic [DATA_W-1:0]      rdata_q;

   logic                   pick_valid;
   logic [IW-1:0]          pick_idx;
   logic [NUM_MASTERS-1:0] pick_gnt;
   logic                   timeout_hit;

   logic [ADDR_W-1:0] addr_arr  [NUM_MASTERS];
   logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
      assign addr_arr[i]  = bus.m_addr[i*ADDR_W +: ADDR_W];
      assign wdata_arr[i] = bus.m_wdata[i*DATA_W +: DATA_W];
   end

   rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
      .req   (bus.m_req),
      .last  (last_q),
      .valid (pick_valid),
      .idx   (pick_idx),
      .gnt   (pick_gnt)
   );

`ifdef TIMER_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt_q;
   logic          err_q;

   assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYC - 1));

   // ACCESS cycle counter, restarted for every new grant; err marks an
   // access that ran out of time without seeing s_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (state == IDLE) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (state == ACCESS && !bus.s_ready) begin
         if (timeout_hit) err_q <= 1'b1;
         else             cnt_q <= cnt_q + CW'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (pick_valid) state_next = ACCESS;
         ACCESS:  if (bus.s_ready || timeout_hit) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Transaction latch, read-data capture and round-robin pointer update.
   always_ff @(posedge clk) begin
      // NOTE: datapath registers are reset as well because their zero
      // values are visible on the bus outputs straight after reset.
      if (rst) begin
         last_q  <= IW'(NUM_MASTERS - 1);
         idx_q   <= '0;
         gnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_valid) begin
                  gnt_q   <= pick_gnt;
                  idx_q   <= pick_idx;
                  we_q    <= bus.m_we[pick_idx];
                  addr_q  <= addr_arr[pick_idx];
                  wdata_q <= wdata_arr[pick_idx];
               end
            end
            ACCESS: begin
               if (bus.s_ready)      rdata_q <= bus.s_rdata;
               else if (timeout_hit) rdata_q <= '0;
            end
            RESP: begin
               last_q <= idx_q;
               gnt_q  <= '0;
            end
            default: ;
         endcase
      end
   end

   // Bus outputs decoded from state and the latched transaction.
   always_comb begin
      bus.m_gnt   = gnt_q;
      bus.m_done  = (state == RESP) ? gnt_q : '0;
      bus.m_rdata = rdata_q;
      bus.s_sel   = (state == ACCESS);
      bus.s_we    = we_q;
      bus.s_addr  = addr_q;
      bus.s_wdata = wdata_q;
      bus.busy    = (state != IDLE);
`ifdef TIMER_ARB_TIMEOUT_EN
      bus.m_err   = (state == RESP && err_q) ? gnt_q : '0;
`endif
   end

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Self-checking bench for timer_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model. Honours TIMER_ARB_TIMEOUT_EN when defined.
module tb_timer_bus_arbiter;
   localparam int N   = 4;
   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   timer_bus_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   timer_bus_arbiter #(
      .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)
`ifdef TIMER_ARB_TIMEOUT_EN
      , .TIMEOUT_CYC(TMO)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   int            mdl_cur  = -1;      // granted master, -1 when none
   bit            mdl_resp = 1'b0;    // transaction finished, done showing
   int            mdl_last = N - 1;
   int            mdl_wait = 0;
   bit            mdl_err  = 1'b0;
   bit            mdl_we   = 1'b0;
   logic [AW-1:0] mdl_addr  = '0;
   logic [DW-1:0] mdl_wdata = '0;
   logic [DW-1:0] mdl_rdata = '0;
   logic [N-1:0]  exp_gnt, exp_done;
   bit            exp_sel, exp_busy;

   always @(posedge clk) begin
      int w;
      if (rst) begin
         mdl_cur = -1; mdl_resp = 1'b0; mdl_last = N - 1;
         mdl_rdata = '0; mdl_err = 1'b0;
      end else if (mdl_cur < 0) begin
         w = -1;
         for (int off = N; off >= 1; off--)
            if (bus.m_req[(mdl_last + off) % N]) w = (mdl_last + off) % N;
         if (w >= 0) begin
            check("pkg_rr_next", 128'(timer_arb_pkg::rr_next(8'(bus.m_req), mdl_last, N)), 128'(w));
            mdl_cur   = w;
            mdl_we    = bus.m_we[w];
            mdl_addr  = bus.m_addr[w*AW +: AW];
            mdl_wdata = bus.m_wdata[w*DW +: DW];
            mdl_wait  = 0;
            mdl_err   = 1'b0;
         end
      end else if (!mdl_resp) begin
         if (bus.s_ready) begin
            mdl_resp  = 1'b1;
            mdl_rdata = bus.s_rdata;
         end
`ifdef TIMER_ARB_TIMEOUT_EN
         else if (mdl_wait == TMO - 1) begin
            mdl_resp = 1'b1; mdl_err = 1'b1; mdl_rdata = '0;
         end else mdl_wait++;
`endif
      end else begin
         mdl_last = mdl_cur; mdl_cur = -1; mdl_resp = 1'b0;
      end
      exp_gnt  = (mdl_cur >= 0) ? (N'(1) << mdl_cur) : '0;
      exp_done = mdl_resp ? exp_gnt : '0;
      exp_sel  = (mdl_cur >= 0) && !mdl_resp;
      exp_busy = (mdl_cur >= 0);
      #1;
      if (cmp_en) begin
         check("m_gnt",  128'(bus.m_gnt),  128'(exp_gnt));
         check("m_done", 128'(bus.m_done), 128'(exp_done));
         check("s_sel",  128'(bus.s_sel),  128'(exp_sel));
         check("busy",   128'(bus.busy),   128'(exp_busy));
         if (exp_sel) begin
            check("s_we",    128'(bus.s_we),    128'(mdl_we));
            check("s_addr",  128'(bus.s_addr),  128'(mdl_addr));
            check("s_wdata", 128'(bus.s_wdata), 128'(mdl_wdata));
         end
         if (mdl_resp) check("m_rdata", 128'(bus.m_rdata), 128'(mdl_rdata));
`ifdef TIMER_ARB_TIMEOUT_EN
         check("m_err", 128'(bus.m_err), 128'(mdl_err ? exp_done : '0));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic nclk();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.m_req = '0; bus.m_we = '0; bus.m_addr = '0; bus.m_wdata = '0;
      bus.s_rdata = '0; bus.s_ready = 1'b0;
   endtask

   task automatic do_reset();
      nclk();
      rst = 1'b1;
      clear_inputs();
      nclk();
      rst = 1'b0;
   endtask

   initial begin
      int done_idx [$];
      int done_cyc [$];
      int cyc;
      int acc;
      bit seen;

      clear_inputs();
      nclk();
      nclk();
      cmp_en = 1'b1;
      check("rst_gnt",   128'(bus.m_gnt),   128'(0));
      check("rst_sel",   128'(bus.s_sel),   128'(0));
      check("rst_busy",  128'(bus.busy),    128'(0));
      check("rst_rdata", 128'(bus.m_rdata), 128'(0));
      check("rst_saddr", 128'(bus.s_addr),  128'(0));
      rst = 1'b0;

      // Single read from master 1.
      bus.m_req = 4'b0010; bus.m_we = '0;
      bus.m_addr = 32'h0000_0800;
      bus.s_ready = 1'b1; bus.s_rdata = 32'hDEAD_BEEF;
      nclk();
      check("single_gnt",   128'(bus.m_gnt),  128'(4'b0010));
      check("single_model", 128'(exp_gnt),    128'(4'b0010));
      check("single_sel",   128'(bus.s_sel),  128'(1));
      check("single_addr",  128'(bus.s_addr), 128'(8'h08));
      nclk();
      check("single_done",  128'(bus.m_done),  128'(4'b0010));
      check("single_rdata", 128'(bus.m_rdata), 128'(32'hDEAD_BEEF));
      bus.m_req = '0;

      // Rotation with all four masters requesting continuously.
      do_reset();
      bus.m_req = 4'b1111; bus.s_ready = 1'b1;
      cyc = 0;
      while (done_idx.size() < 5 && cyc < 60) begin
         nclk();
         cyc++;
         for (int i = 0; i < N; i++)
            if (bus.m_done[i]) begin done_idx.push_back(i); done_cyc.push_back(cyc); end
      end
      check("rot_count", 128'(done_idx.size()), 128'(5));
      for (int k = 0; k < done_idx.size(); k++) begin
         check("rot_order", 128'(done_idx[k]), 128'(k % N));
         if (k > 0) check("rot_period", 128'(done_cyc[k] - done_cyc[k-1]), 128'(3));
      end
      bus.m_req = '0;

      // Wait states on a write from master 2; master 0 requests meanwhile.
      do_reset();
      bus.m_req = 4'b0100; bus.m_we = 4'b0100;
      bus.m_addr = 32'h0004_0000; bus.m_wdata = {32'h0, 32'h5, 64'h0};
      bus.s_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         nclk();
         check("ws_sel",   128'(bus.s_sel),   128'(1));
         check("ws_we",    128'(bus.s_we),    128'(1));
         check("ws_addr",  128'(bus.s_addr),  128'(8'h04));
         check("ws_wdata", 128'(bus.s_wdata), 128'(32'h5));
         check("ws_gnt",   128'(bus.m_gnt),   128'(4'b0100));
         bus.m_req = 4'b0101;
         bus.m_addr = $urandom; bus.m_wdata = {$urandom, $urandom, $urandom, $urandom};
         if (i == 5) bus.s_ready = 1'b1;
      end
      nclk();
      check("ws_done", 128'(bus.m_done), 128'(4'b0100));
      bus.m_req = 4'b0001;
      nclk();
      check("ws_idle", 128'(bus.busy), 128'(0));
      nclk();
      check("ws_next_gnt", 128'(bus.m_gnt), 128'(4'b0001));
      nclk();
      bus.m_req = '0;

      // Master 3 drops its request during ACCESS.
      do_reset();
      bus.m_req = 4'b1000;
      nclk();
      bus.m_req = 4'b0010; bus.s_ready = 1'b1;
      nclk();
      check("drop_done", 128'(bus.m_done), 128'(4'b1000));
      nclk();
      nclk();
      check("drop_next_gnt", 128'(bus.m_gnt), 128'(4'b0010));
      nclk();
      bus.m_req = '0;

      // Reset during ACCESS.
      do_reset();
      bus.m_req = 4'b0100;
      nclk();
      check("rmid_sel_before", 128'(bus.s_sel), 128'(1));
      rst = 1'b1;
      nclk();
      check("rmid_sel",  128'(bus.s_sel), 128'(0));
      check("rmid_gnt",  128'(bus.m_gnt), 128'(0));
      check("rmid_busy", 128'(bus.busy),  128'(0));
      rst = 1'b0; bus.m_req = 4'b0101;
      nclk();
      check("rmid_first", 128'(bus.m_gnt), 128'(4'b0001));
      bus.m_req = '0;

`ifdef TIMER_ARB_TIMEOUT_EN
      // Slave never answers: access must expire after TMO cycles.
      do_reset();
      bus.m_req = 4'b0010; bus.s_ready = 1'b0; bus.s_rdata = 32'h1234_5678;
      acc = 0; seen = 1'b0; cyc = 0;
      while (!seen && cyc < 60) begin
         nclk();
         cyc++;
         if (bus.s_sel) acc++;
         if (bus.m_done != '0) begin
            seen = 1'b1;
            check("tmo_done",  128'(bus.m_done),  128'(4'b0010));
            check("tmo_err",   128'(bus.m_err),   128'(4'b0010));
            check("tmo_rdata", 128'(bus.m_rdata), 128'(0));
         end
      end
      check("tmo_seen",   128'(seen), 128'(1));
      check("tmo_cycles", 128'(acc),  128'(TMO));
      bus.m_req = '0;
`endif

      // Randomized traffic, checked every cycle by the model process.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         nclk();
         rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < N; i++) begin
            if (bus.m_req[i]) begin
               if (bus.m_done[i])                  bus.m_req[i] = 1'($urandom_range(0, 1));
               else if ($urandom_range(0, 29) == 0) bus.m_req[i] = 1'b0;
            end else begin
               bus.m_req[i] = ($urandom_range(0, 3) == 0);
            end
         end
         bus.m_we    = 4'($urandom);
         bus.m_addr  = $urandom;
         bus.m_wdata = {$urandom, $urandom, $urandom, $urandom};
         bus.s_ready = ($urandom_range(0, 2) != 0);
         bus.s_rdata = $urandom;
      end
      nclk();
      nclk();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
